// File: rtl/mul_unit_seq_if.sv
// rtl/mul_unit_seq_if.sv - start/busy/done handshake and hi/lo result bundle for mul_unit_seq
interface mul_unit_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_unit_seq.sv
// rtl/mul_unit_seq.sv - sequential radix-2 shift-add MULT/MULTU unit with hi/lo result registers
module mul_unit_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mul_unit_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic               accept;

    // Magnitudes are W-bit unsigned, so -2^(W-1) maps cleanly to 2^(W-1).
    always_comb begin
        mag_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
        mag_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
    end

    // Upper half plus carry bit receives the multiplicand; lower half holds the
    // remaining multiplier bits and fills with product bits as it shifts.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        acc_step = acc[0] ? {sum, acc[WIDTH-1:0]} : acc;
        prod     = acc[2*WIDTH-1:0];
        prod_fix = neg ? (~prod + 1'b1) : prod;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= {{(WIDTH + 1){1'b0}}, mag_b};
                        mcand  <= mag_a;
                        neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_step >> 1;
                    cnt <= cnt + CW'(1);
                end
                FINISH: begin
                    {hi_r, lo_r} <= prod_fix;
                    done_r       <= 1'b1;
                    busy_r       <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule
